// File: rtl/conv3x3_mac_pipe.sv
// 3x3 signed convolution MAC: a three-stage pipeline (multiply, accumulate plus bias,
// requantise), with writable kernel and bias registers and an output frame counter.
module conv3x3_mac_pipe #(
  parameter int ACC_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic signed [7:0] win0,
  input  logic signed [7:0] win1,
  input  logic signed [7:0] win2,
  input  logic signed [7:0] win3,
  input  logic signed [7:0] win4,
  input  logic signed [7:0] win5,
  input  logic signed [7:0] win6,
  input  logic signed [7:0] win7,
  input  logic signed [7:0] win8,
  input  logic              w_load,
  input  logic [3:0]        w_addr,
  input  logic signed [7:0] w_data,
  input  logic              b_load,
  input  logic signed [15:0] b_data,
  input  logic [3:0]        shift,
  input  logic              relu_en,
  input  logic [7:0]        img_width,
  input  logic [7:0]        img_height,
  output logic signed [7:0] data_out,
  output logic              valid_out,
  output logic              frame_done
);

  localparam int N_TAPS = 9;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-128);

  logic signed [7:0]       win    [N_TAPS];
  logic signed [7:0]       weight [N_TAPS];
  logic signed [15:0]      bias;

  logic                    v1;
  logic signed [15:0]      prod   [N_TAPS];
  logic                    v2;
  logic signed [ACC_W-1:0] acc;
  logic [15:0]             frame_cnt;

  assign win[0] = win0;
  assign win[1] = win1;
  assign win[2] = win2;
  assign win[3] = win3;
  assign win[4] = win4;
  assign win[5] = win5;
  assign win[6] = win6;
  assign win[7] = win7;
  assign win[8] = win8;

  // NOTE: the kernel is a small register file, not RAM, so it is reset like any other
  // flop; after reset every tap reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TAPS; i++) weight[i] <= '0;
      bias <= '0;
    end else begin
      if (w_load && (w_addr < 4'd9)) weight[w_addr] <= w_data;
      if (b_load) bias <= b_data;
    end
  end

  // Stage 1: the products use the weights held before this edge, so a kernel write in
  // the same cycle only affects later windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) prod[i] <= '0;
    end else begin
      v1 <= valid_in;
      if (valid_in) begin
        for (int i = 0; i < N_TAPS; i++) prod[i] <= win[i] * weight[i];
      end
    end
  end

  // Stage 2: sum the products and the bias at full accumulator width.
  logic signed [ACC_W-1:0] sum_c;

  // NOTE: combinational blocks use blocking '=' and assign a default first, so no
  // latch is inferred and later statements see the updated value.
  always_comb begin
    sum_c = {{(ACC_W-16){bias[15]}}, bias};
    for (int i = 0; i < N_TAPS; i++) begin
      sum_c = sum_c + {{(ACC_W-16){prod[i][15]}}, prod[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2  <= 1'b0;
      acc <= '0;
    end else begin
      v2 <= v1;
      if (v1) acc <= sum_c;
    end
  end

  // Stage 3: round half up, arithmetic shift, optional ReLU, saturate to int8.
  logic [ACC_W-1:0]        rnd_add_c;
  logic signed [ACC_W-1:0] round_c;
  logic signed [ACC_W-1:0] shifted_c;
  logic signed [ACC_W-1:0] clip_c;
  logic signed [7:0]       sat_c;

  always_comb begin
    rnd_add_c = ({{(ACC_W-1){1'b0}}, 1'b1} << shift) >> 1;
    round_c   = acc + rnd_add_c;
    shifted_c = round_c >>> shift;
    clip_c    = shifted_c;
    if (relu_en && shifted_c[ACC_W-1]) clip_c = '0;
    sat_c = clip_c[7:0];
    if (clip_c > SAT_MAX)      sat_c = 8'sd127;
    else if (clip_c < SAT_MIN) sat_c = -8'sd128;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      valid_out <= v2;
      if (v2) data_out <= sat_c;
    end
  end

  // Frame counter advances with each result leaving stage 3; a zero-sized map disables it.
  logic [15:0] frame_total_c;
  assign frame_total_c = {8'd0, img_width} * {8'd0, img_height};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (v2) begin
        if (frame_total_c == 16'd0) begin
          frame_cnt <= '0;
        end else if (frame_cnt + 16'd1 == frame_total_c) begin
          frame_cnt  <= '0;
          frame_done <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_mac_pipe.sv
// Directed bench for conv3x3_mac_pipe: identity, saturation, rounding, weight-write race,
// frame counting with bubbles and reset in the middle of a stream.
module tb_conv3x3_mac_pipe;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid_in;
  logic signed [7:0] win [9];
  logic              w_load;
  logic [3:0]        w_addr;
  logic signed [7:0] w_data;
  logic              b_load;
  logic signed [15:0] b_data;
  logic [3:0]        shift;
  logic              relu_en;
  logic [7:0]        img_width;
  logic [7:0]        img_height;
  logic signed [7:0] data_out;
  logic              valid_out;
  logic              frame_done;

  int checks   = 0;
  int failures = 0;

  conv3x3_mac_pipe #(.ACC_W(20)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .win0       (win[0]),
    .win1       (win[1]),
    .win2       (win[2]),
    .win3       (win[3]),
    .win4       (win[4]),
    .win5       (win[5]),
    .win6       (win[6]),
    .win7       (win[7]),
    .win8       (win[8]),
    .w_load     (w_load),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .b_load     (b_load),
    .b_data     (b_data),
    .shift      (shift),
    .relu_en    (relu_en),
    .img_width  (img_width),
    .img_height (img_height),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 9; i++) win[i] = 8'(v);
  endtask

  task automatic load_w(input int addr, input int data);
    w_load = 1'b1;
    w_addr = 4'(addr);
    w_data = 8'(data);
    step();
    w_load = 1'b0;
  endtask

  task automatic load_b(input int data);
    b_load = 1'b1;
    b_data = 16'(data);
    step();
    b_load = 1'b0;
  endtask

  // One isolated window: the result must appear exactly three edges after acceptance.
  task automatic run_window(input string tag, input int exp, input bit fd_exp);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step();
    check({tag, "_early"}, valid_out, 0);
    step();
    check({tag, "_valid"}, valid_out, 1);
    check({tag, "_data"}, data_out, exp);
    check({tag, "_fdone"}, frame_done, fd_exp);
  endtask

  initial begin
    int k;
    int outs;
    int last_exp;
    int exp_q[$];
    bit vs[32];
    bit exp_v;
    int e;

    rst_n = 1'b0;
    valid_in = 1'b0;
    fill(0);
    w_load = 1'b0; w_addr = '0; w_data = '0;
    b_load = 1'b0; b_data = '0;
    shift = '0; relu_en = 1'b0;
    img_width = 8'd0; img_height = 8'd5;
    step();
    step();
    check("rst_data", data_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_fdone", frame_done, 0);
    rst_n = 1'b1;
    step();

    // Identity kernel; other taps carry nonzero pixels to prove their weights reset to 0.
    load_w(4, 1);
    fill(9); win[4] = 37;
    run_window("ident_pos", 37, 0);
    win[4] = -90;
    run_window("ident_neg", -90, 0);

    // Out-of-range addresses must not alias onto a real tap.
    load_w(9, 55);
    load_w(12, 55);
    load_w(15, 55);
    fill(1);
    run_window("addr_ignore", 1, 0);

    // Saturation: 9*127*127 = 145161 and 9*127*-128 = -146304.
    for (int i = 0; i < 9; i++) load_w(i, 127);
    fill(127);
    run_window("sat_pos", 127, 0);
    fill(-128);
    run_window("sat_neg", -128, 0);
    relu_en = 1'b1;
    run_window("sat_relu", 0, 0);
    relu_en = 1'b0;

    // Rounding: (5+1)>>1=3, (-5+1)>>>1=-2, (100+2)>>2=25.
    for (int i = 0; i < 9; i++) load_w(i, (i == 4) ? 1 : 0);
    fill(0);
    shift = 4'd1;
    win[4] = 5;
    run_window("round_pos", 3, 0);
    win[4] = -5;
    run_window("round_neg", -2, 0);
    load_b(100);
    shift = 4'd2;
    win[4] = 0;
    run_window("round_bias", 25, 0);
    load_b(0);
    shift = 4'd0;

    // Weight write in the same cycle as the first of two back-to-back windows.
    load_w(4, 0);
    load_w(0, 2);
    fill(0); win[0] = 10;
    valid_in = 1'b1;
    w_load = 1'b1; w_addr = 4'd0; w_data = 8'sd3;
    step();
    w_load = 1'b0;
    step();
    valid_in = 1'b0;
    check("race_early", valid_out, 0);
    step();
    check("race_v1", valid_out, 1);
    check("race_d1", data_out, 20);
    step();
    check("race_v2", valid_out, 1);
    check("race_d2", data_out, 30);
    step();
    check("race_v3", valid_out, 0);
    check("race_hold", data_out, 30);

    // Two 4x2 frames: the first with bubbles, the second back to back.
    load_w(0, 2);
    img_width = 8'd4; img_height = 8'd2;
    fill(0);
    k = 0; outs = 0; last_exp = 30;
    for (int c = 0; c < 26; c++) begin
      vs[c] = (c inside {0, 2, 3, 6, 7, 9, 13, 14}) || (c >= 15 && c <= 22);
      valid_in = vs[c];
      if (vs[c]) begin
        win[0] = 8'(k);
        exp_q.push_back(2 * k);
        k++;
      end
      step();
      exp_v = (c >= 2) ? vs[c-2] : 1'b0;
      check("frm_valid", valid_out, exp_v);
      if (exp_v) begin
        e = exp_q.pop_front();
        outs++;
        last_exp = e;
        check("frm_data", data_out, e);
        check("frm_fdone", frame_done, (outs % 8 == 0) ? 1 : 0);
      end else begin
        check("frm_hold", data_out, last_exp);
        check("frm_fdone_idle", frame_done, 0);
      end
    end
    valid_in = 1'b0;
    check("frm_count", outs, 16);

    // Leave the frame counter at 3, then reset with two windows in flight.
    fill(0); win[0] = 1;
    for (int i = 0; i < 3; i++) run_window("pre_rst", 2, 0);
    fill(1);
    valid_in = 1'b1;
    step();
    step();
    valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_data", data_out, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_quiet", valid_out, 0);
    end
    run_window("rst_ones", 0, 0);

    // Counter restarted from 0: one frame is the window above plus seven more.
    load_w(0, 2);
    fill(0); win[0] = 1;
    for (int i = 0; i < 6; i++) run_window("rst_frame", 2, 0);
    run_window("rst_frame_last", 2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv3x3_mac_pipe.md
CONV3X3_MAC_PIPE -- requirements
Module: conv3x3_mac_pipe

Interface
REQ-001 Parameter ACC_W, default 20: accumulator width in bits; SHALL be at least 20.
REQ-002 Port clk, input, 1: single clock; all state SHALL update on the rising edge.
REQ-003 Port rst_n, input, 1: asynchronous active-low reset.
REQ-004 Port valid_in, input, 1: the window on win0..win8 is valid this cycle.
REQ-005 Ports win0..win8, input, signed 8 each: 3x3 window in row-major order; win0 is top-left, win4 is centre, win8 is bottom-right.
REQ-006 Port w_load, input, 1: kernel weight write strobe.
REQ-007 Port w_addr, input, 4: kernel weight index 0..8.
REQ-008 Port w_data, input, signed 8: kernel weight value.
REQ-009 Port b_load, input, 1: bias write strobe.
REQ-010 Port b_data, input, signed 16: bias value.
REQ-011 Port shift, input, 4: requantisation right-shift amount 0..15.
REQ-012 Port relu_en, input, 1: clamps negative results to 0 when high.
REQ-013 Ports img_width and img_height, input, 8 each: output-map dimensions used by the frame counter.
REQ-014 Port data_out, output, signed 8: requantised convolution result.
REQ-015 Port valid_out, output, 1: data_out is valid this cycle.
REQ-016 Port frame_done, output, 1: one-cycle pulse coincident with the last valid_out of a frame.

Function
REQ-017 Weights SHALL be held in 9 signed 8-bit registers and bias in one signed 16-bit register.
- w_load with w_addr 0..8 SHALL write weight[w_addr].
- w_load with w_addr 9..15 SHALL be ignored.
REQ-018 The pipeline SHALL have exactly 3 stages: valid_in at cycle N SHALL produce valid_out at cycle N+3.
- The pipeline SHALL have no stalls and no backpressure.
- Back-to-back valid_in SHALL give back-to-back valid_out.
REQ-019 Stage 1 SHALL register the 9 signed 16-bit products win_k*weight[k] using the weights held before the current edge.
- A weight or bias write in the same cycle as valid_in SHALL NOT affect that window.
REQ-020 Stage 2 SHALL register sum of the 9 products plus the sign-extended bias, computed in ACC_W-bit signed arithmetic.
- The sum SHALL never overflow: worst case is 9*16384 + 32768 = 180224.
REQ-021 Stage 3 requantisation SHALL apply these steps in order, using the shift and relu_en values sampled at stage 3:
- If shift > 0, add the rounding constant 1<<(shift-1).
- Arithmetic right shift by shift.
- If relu_en is high, force negative values to 0.
- Saturate to the range -128..127.
REQ-022 Bubbles (valid_in low) SHALL propagate as valid_out low; data_out SHALL hold its last value while valid_out is low.
REQ-023 The frame counter SHALL count valid_out pulses.
- frame_done SHALL assert with the valid_out for which count+1 equals img_width*img_height, computed as a 16-bit product.
- The counter SHALL then wrap to 0.
REQ-024 If img_width or img_height is 0, frame_done SHALL never assert and the counter SHALL stay at 0.
REQ-025 Changing img_width or img_height mid-frame SHALL take effect on the next compare; no recovery is defined beyond REQ-023.

Reset
REQ-026 While rst_n is low, all of the following SHALL be 0: data_out, valid_out, frame_done, all pipeline valid bits and data registers, weights, bias, and the frame counter.
REQ-027 Asserting rst_n mid-operation SHALL discard in-flight windows: no valid_out SHALL appear for windows accepted before reset.
REQ-028 The first valid_in accepted after rst_n deasserts SHALL produce valid_out exactly 3 cycles later.

Verification
REQ-029 Identity kernel:
- Setup: weight[4]=1, all other weights 0, bias 0, shift 0, relu_en 0.
- Stimulus: win4=37 at cycle N -> data_out=37 with valid_out at N+3.
- Stimulus: win4=-90 -> data_out=-90.
REQ-030 Saturation:
- Setup: all weights 127, bias 0, shift 0.
- All win=127 -> data_out=127.
- All win=-128 -> data_out=-128.
- All win=-128 with relu_en=1 -> data_out=0.
REQ-031 Rounding:
- Setup: weight[4]=1, shift=1.
- win4=5 -> 3.
- win4=-5 -> -2.
- Setup: bias=100, shift=2, win4=0 -> 25.
REQ-032 Weight write race: weight[0]=2 and win0=10 on consecutive valid_in windows; w_load writes weight[0]=3 in the same cycle as the first window -> outputs 20 then 30.
REQ-033 Frame and bubbles: img_width=4, img_height=2, 8 windows fed with random gaps -> 8 valid_out pulses; frame_done only on the 8th; the counter restarts for the next frame.
REQ-034 Reset mid-stream: rst_n pulsed low one cycle after 2 windows accepted -> no valid_out from those windows; weights read back as 0 (an all-ones window gives output 0).
